uart_echo_engine: RTL and testbench
===================================

UART_ECHO_ENGINE -- requirements
Module: uart_echo_engine

Interface
REQ-001 SHALL have parameter DBIT, default 8, UART data word width in bits.
REQ-002 SHALL have parameter OFFSET, default 1, value added to each byte in increment mode, taken modulo 2^DBIT.
REQ-003 SHALL have parameter BURST_LEN, default 16, number of words per burst (range 1..2^DBIT).
REQ-004 SHALL have parameter CW, default 16, width of the traffic counters.
REQ-005 SHALL have port clk, input, 1, the single system clock; all logic on its rising edge.
REQ-006 SHALL have port reset, input, 1, synchronous, active-low reset.
REQ-007 SHALL have port mode, input, 2: 00 echo, 01 increment, 10 invert, 11 burst.
REQ-008 SHALL have port auto_en, input, 1: 1 = service the RX FIFO continuously; 0 = one word per btn_tick.
REQ-009 SHALL have port btn_tick, input, 1, single-cycle debounced button pulse.
REQ-010 SHALL have port rx_empty, input, 1, UART RX FIFO empty flag.
REQ-011 SHALL have port r_data, input, DBIT, RX FIFO head word (first-word-fall-through, valid while rx_empty=0).
REQ-012 SHALL have port tx_full, input, 1, UART TX FIFO full flag.
REQ-013 SHALL have port rd_uart, output, 1, RX FIFO pop strobe.
REQ-014 SHALL have port wr_uart, output, 1, TX FIFO push strobe.
REQ-015 SHALL have port w_data, output, DBIT, TX FIFO write word.
REQ-016 SHALL have port led, output, DBIT, last word popped from the RX FIFO.
REQ-017 SHALL have port rx_count, output, CW, total words popped.
REQ-018 SHALL have port tx_count, output, CW, total words pushed.
REQ-019 SHALL have port busy, output, 1, high whenever the FSM is not in IDLE.

Function
REQ-020 SHALL implement the FSM states IDLE, WRITE and BURST.
REQ-021 SHALL, in IDLE, start a service (the "go" condition) when auto_en=1, or when auto_en=0 and btn_tick=1.
REQ-022 SHALL, on go with rx_empty=0 and mode!=11: pulse rd_uart for one cycle, capture r_data into led and a hold register, latch mode, and enter WRITE.
REQ-023 SHALL ignore go in IDLE when rx_empty=1 and mode!=11: no strobe is issued, no state change occurs, and the btn_tick is discarded rather than queued.
REQ-024 SHALL, in WRITE with tx_full=0: pulse wr_uart for one cycle with w_data = f(hold), then return to IDLE.
REQ-025 SHALL use f = hold for latched mode 00, hold+OFFSET modulo 2^DBIT (wrapping) for 01, and ~hold for 10.
REQ-026 SHALL stay in WRITE while tx_full=1, holding w_data stable with wr_uart=0.
REQ-027 SHALL enter BURST, with its word index cleared to 0, on btn_tick=1 in IDLE with mode=11, regardless of auto_en and rx_empty.
REQ-028 SHALL, in BURST, push the index value (zero-extended to DBIT) each cycle that tx_full=0, then increment the index.
REQ-029 SHALL stall in BURST without pushing while tx_full=1.
REQ-030 SHALL return to IDLE after the push of index BURST_LEN-1.
REQ-031 SHALL never pop the RX FIFO during BURST.
REQ-032 SHALL never assert rd_uart and wr_uart in the same cycle.
REQ-033 SHALL give a minimum echo latency of one cycle from the rd_uart pulse to the wr_uart pulse, yielding a maximum throughput of one word per two cycles.
REQ-034 SHALL ignore btn_tick and mode changes while busy=1; the latched mode governs the word or burst in flight.
REQ-035 SHALL increment rx_count on every rd_uart pulse and tx_count on every wr_uart pulse, wrapping from 2^CW-1 to 0.

Reset
REQ-036 SHALL, with reset=0 at a clock edge, force state to IDLE and set rd_uart=0, wr_uart=0, w_data=0, led=0, rx_count=0, tx_count=0, busy=0, burst index=0 and hold register=0.
REQ-037 SHALL, on reset asserted mid-WRITE or mid-BURST, abandon the word or burst in flight without issuing any further strobe.

Verification
REQ-038 SHALL cover increment wrap: mode=01, auto_en=1, RX FIFO holds 0x41 then 0xFF -> pushes of 0x42 then 0x00, rx_count=2, tx_count=2, led=0xFF.
REQ-039 SHALL cover manual mode: auto_en=0, RX FIFO holds 0x10 and 0x20, one btn_tick -> exactly one pop and one push of 0x10 (mode=00); second word remains in the FIFO.
REQ-040 SHALL cover TX back-pressure: mode=10, r_data=0x5A, tx_full=1 for 5 cycles -> wr_uart=0 and w_data=0xA5 stable throughout, then a single push of 0xA5 on the first cycle with tx_full=0.
REQ-041 SHALL cover a stalled burst: mode=11, BURST_LEN=4, btn_tick with tx_full toggling -> pushes 0x00, 0x01, 0x02, 0x03 in order, no rd_uart pulses, busy falls after 0x03.
REQ-042 SHALL cover a mode change mid-word: mode switched 01->00 while in WRITE -> the pushed word still uses the increment transform.
REQ-043 SHALL cover reset mid-burst: reset=0 after two burst pushes -> next cycle shows busy=0 and both counters at 0, and no further wr_uart pulses occur.

Source files
------------

// File: rtl/uart_echo_engine.sv
// UART echo/transform engine: pops words from the RX FIFO, transforms them and
// pushes them to the TX FIFO, or emits a counting burst of BURST_LEN words.
module uart_echo_engine #(
    parameter int DBIT      = 8,
    parameter int OFFSET    = 1,
    parameter int BURST_LEN = 16,
    parameter int CW        = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [1:0]      mode,
    input  logic            auto_en,
    input  logic            btn_tick,
    input  logic            rx_empty,
    input  logic [DBIT-1:0] r_data,
    input  logic            tx_full,
    output logic            rd_uart,
    output logic            wr_uart,
    output logic [DBIT-1:0] w_data,
    output logic [DBIT-1:0] led,
    output logic [CW-1:0]   rx_count,
    output logic [CW-1:0]   tx_count,
    output logic            busy
);

    typedef enum logic [1:0] {ST_IDLE, ST_WRITE, ST_BURST} state_t;

    localparam logic [DBIT-1:0] W_OFFSET = DBIT'(OFFSET);
    localparam logic [DBIT-1:0] W_LAST   = DBIT'(BURST_LEN - 1);

    state_t          r_state;
    logic [1:0]      r_mode;
    logic [DBIT-1:0] r_hold;
    logic [DBIT-1:0] r_idx;
    logic            r_rd;
    logic            r_wr;
    logic [DBIT-1:0] r_wdata;
    logic [DBIT-1:0] r_led;
    logic [CW-1:0]   r_rx_cnt;
    logic [CW-1:0]   r_tx_cnt;
    logic            w_go;

    function automatic logic [DBIT-1:0] xform(input logic [1:0] m, input logic [DBIT-1:0] d);
        case (m)
            2'b01:   return d + W_OFFSET;
            2'b10:   return ~d;
            default: return d;
        endcase
    endfunction

    assign w_go = auto_en | btn_tick;

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state  <= ST_IDLE;
            r_mode   <= 2'b00;
            r_hold   <= '0;
            r_idx    <= '0;
            r_rd     <= 1'b0;
            r_wr     <= 1'b0;
            r_wdata  <= '0;
            r_led    <= '0;
            r_rx_cnt <= '0;
            r_tx_cnt <= '0;
        end else begin
            r_rd <= 1'b0;
            r_wr <= 1'b0;
            case (r_state)
                ST_IDLE: begin
                    // Burst is button-only; a go with an empty FIFO is simply dropped.
                    if (btn_tick && mode == 2'b11) begin
                        r_state <= ST_BURST;
                        r_idx   <= '0;
                        r_mode  <= mode;
                    end else if (w_go && !rx_empty && mode != 2'b11) begin
                        r_rd     <= 1'b1;
                        r_rx_cnt <= r_rx_cnt + 1'b1;
                        r_led    <= r_data;
                        r_hold   <= r_data;
                        r_mode   <= mode;
                        r_wdata  <= xform(mode, r_data);
                        r_state  <= ST_WRITE;
                    end
                end
                ST_WRITE: begin
                    // w_data already carries the result, so a stall leaves it stable.
                    if (!tx_full) begin
                        r_wr     <= 1'b1;
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                        r_wdata  <= xform(r_mode, r_hold);
                        r_state  <= ST_IDLE;
                    end
                end
                ST_BURST: begin
                    if (!tx_full) begin
                        r_wr     <= 1'b1;
                        r_tx_cnt <= r_tx_cnt + 1'b1;
                        r_wdata  <= r_idx;
                        r_idx    <= r_idx + 1'b1;
                        if (r_idx == W_LAST)
                            r_state <= ST_IDLE;
                    end
                end
                default: r_state <= ST_IDLE;
            endcase
        end
    end

    assign rd_uart  = r_rd;
    assign wr_uart  = r_wr;
    assign w_data   = r_wdata;
    assign led      = r_led;
    assign rx_count = r_rx_cnt;
    assign tx_count = r_tx_cnt;
    assign busy     = (r_state != ST_IDLE);

endmodule

// File: tb/tb_uart_echo_engine.sv
// Directed bench for uart_echo_engine with a small RX FIFO model and a TX push log.
module tb_uart_echo_engine;

    logic        clk = 1'b0;
    logic        reset;
    logic [1:0]  mode;
    logic        auto_en;
    logic        btn_tick;
    logic        rx_empty = 1'b1;
    logic [7:0]  r_data = 8'h00;
    logic        tx_full;
    logic        rd_uart;
    logic        wr_uart;
    logic [7:0]  w_data;
    logic [7:0]  led;
    logic [15:0] rx_count;
    logic [15:0] tx_count;
    logic        busy;

    int n_cmp = 0;
    int n_err = 0;
    int cyc   = 0;
    bit both_seen = 1'b0;

    logic [7:0] rxq[$];
    logic [7:0] tx_log[$];
    int         rd_q[$];
    int         wr_q[$];

    uart_echo_engine #(.DBIT(8), .OFFSET(1), .BURST_LEN(4), .CW(16)) dut (
        .clk(clk), .reset(reset), .mode(mode), .auto_en(auto_en), .btn_tick(btn_tick),
        .rx_empty(rx_empty), .r_data(r_data), .tx_full(tx_full),
        .rd_uart(rd_uart), .wr_uart(wr_uart), .w_data(w_data), .led(led),
        .rx_count(rx_count), .tx_count(tx_count), .busy(busy)
    );

    always #5 clk = ~clk;

    // FIFO model and strobe monitor; the initial block acts 1 time unit later.
    always @(negedge clk) begin
        cyc++;
        if (rd_uart) begin
            if (rxq.size() > 0) void'(rxq.pop_front());
            rd_q.push_back(cyc);
        end
        if (wr_uart) begin
            tx_log.push_back(w_data);
            wr_q.push_back(cyc);
        end
        if (rd_uart && wr_uart) both_seen = 1'b1;
        rx_empty = (rxq.size() == 0);
        r_data   = (rxq.size() == 0) ? 8'h00 : rxq[0];
    end

    task automatic tick(input int n = 1);
        repeat (n) begin
            @(negedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] log_at(input int i);
        return (i < tx_log.size()) ? {24'h0, tx_log[i]} : 32'hDEAD;
    endfunction

    task automatic clear_logs();
        tx_log.delete();
        rd_q.delete();
        wr_q.delete();
    endtask

    task automatic do_reset();
        reset = 1'b0;
        tick(2);
        reset = 1'b1;
        tick(1);
    endtask

    initial begin
        reset = 1'b0; mode = 2'b00; auto_en = 1'b0; btn_tick = 1'b0; tx_full = 1'b0;
        tick(3);
        chk("rst_busy", busy, 0);
        chk("rst_rd", rd_uart, 0);
        chk("rst_wr", wr_uart, 0);
        chk("rst_wdata", w_data, 0);
        chk("rst_led", led, 0);
        chk("rst_rxcnt", rx_count, 0);
        chk("rst_txcnt", tx_count, 0);
        reset = 1'b1;
        tick(1);

        // Manual mode: one button press moves exactly one word.
        rxq.push_back(8'h10); rxq.push_back(8'h20);
        tick(1);
        btn_tick = 1'b1; tick(1); btn_tick = 1'b0;
        tick(5);
        chk("man_pushes", tx_log.size(), 1);
        chk("man_word", log_at(0), 32'h10);
        chk("man_pops", rd_q.size(), 1);
        chk("man_left", rxq.size(), 1);
        chk("man_led", led, 8'h10);

        // Increment mode with wrap, continuous service.
        rxq.delete();
        do_reset();
        clear_logs();
        rxq.push_back(8'h41); rxq.push_back(8'hFF);
        tick(1);
        mode = 2'b01; auto_en = 1'b1;
        tick(8);
        auto_en = 1'b0;
        chk("inc_pushes", tx_log.size(), 2);
        chk("inc_w0", log_at(0), 32'h42);
        chk("inc_w1", log_at(1), 32'h00);
        chk("inc_rxcnt", rx_count, 2);
        chk("inc_txcnt", tx_count, 2);
        chk("inc_led", led, 8'hFF);
        chk("inc_latency", (rd_q.size() > 0 && wr_q.size() > 0) ? wr_q[0] - rd_q[0] : -1, 1);
        chk("inc_rate", (rd_q.size() > 1) ? rd_q[1] - rd_q[0] : -1, 2);

        // Back-pressure in invert mode.
        clear_logs();
        mode = 2'b10; tx_full = 1'b1;
        rxq.push_back(8'h5A);
        tick(1);
        btn_tick = 1'b1; tick(1); btn_tick = 1'b0;
        chk("bp_wr0", wr_uart, 0);
        chk("bp_wd0", w_data, 8'hA5);
        for (int i = 0; i < 4; i++) begin
            tick(1);
            chk("bp_wr_stall", wr_uart, 0);
            chk("bp_wd_stall", w_data, 8'hA5);
        end
        chk("bp_busy", busy, 1);
        tx_full = 1'b0;
        tick(1);
        chk("bp_wr_go", wr_uart, 1);
        chk("bp_wd_go", w_data, 8'hA5);
        tick(1);
        chk("bp_wr_after", wr_uart, 0);
        chk("bp_pushes", tx_log.size(), 1);
        chk("bp_busy_end", busy, 0);

        // Mode change while a word is held in WRITE.
        clear_logs();
        mode = 2'b01; tx_full = 1'b1;
        rxq.push_back(8'h30);
        tick(1);
        btn_tick = 1'b1; tick(1); btn_tick = 1'b0;
        mode = 2'b00;
        tick(2);
        tx_full = 1'b0;
        tick(3);
        chk("mc_pushes", tx_log.size(), 1);
        chk("mc_word", log_at(0), 32'h31);

        // Burst: auto_en alone must not start it, and it must not pop.
        clear_logs();
        mode = 2'b11; auto_en = 1'b1;
        rxq.push_back(8'h77);
        tick(4);
        chk("bu_nostart", busy, 0);
        chk("bu_nopop_idle", rd_q.size(), 0);
        btn_tick = 1'b1; tick(1); btn_tick = 1'b0;
        for (int i = 0; i < 12; i++) begin
            tx_full = i[0];
            tick(1);
        end
        tx_full = 1'b0;
        tick(3);
        chk("bu_pushes", tx_log.size(), 4);
        chk("bu_w0", log_at(0), 32'h00);
        chk("bu_w1", log_at(1), 32'h01);
        chk("bu_w2", log_at(2), 32'h02);
        chk("bu_w3", log_at(3), 32'h03);
        chk("bu_nopop", rd_q.size(), 0);
        chk("bu_fifo", rxq.size(), 1);
        chk("bu_busy_end", busy, 0);
        auto_en = 1'b0;
        rxq.delete();
        tick(1);

        // Reset in the middle of a burst.
        clear_logs();
        mode = 2'b11;
        btn_tick = 1'b1; tick(1); btn_tick = 1'b0;
        for (int k = 0; k < 10 && tx_log.size() < 2; k++) tick(1);
        chk("rb_pre", tx_log.size(), 2);
        reset = 1'b0;
        tick(1);
        chk("rb_busy", busy, 0);
        chk("rb_rxcnt", rx_count, 0);
        chk("rb_txcnt", tx_count, 0);
        chk("rb_wr", wr_uart, 0);
        reset = 1'b1;
        tick(8);
        chk("rb_nomore", tx_log.size(), 2);

        chk("no_rd_wr_overlap", both_seen, 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
